// File: rtl/ofm_collector.sv
// ofm_collector: captures one byte per PE lane when all lanes are valid, packs each capture
// into big-endian words and streams them into the OFM BRAM. Revision 1.0.
`default_nettype none

module ofm_collector #(
  parameter int NUM_PE     = 16,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 20,
  parameter int OFM_PIXELS = 3136
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     cal_start_i,
  input  logic [NUM_PE-1:0]        valid_i,
  input  logic [NUM_PE*DATA_W-1:0] ofm_in_i,
  input  logic                     wr_ready_i,
  output logic                     wr_en_o,
  output logic [ADDR_W-1:0]        wr_addr_o,
  output logic [4*DATA_W-1:0]      wr_data_o,
  output logic [15:0]              pixel_cnt_o,
  output logic                     done_o,
  output logic                     overflow_o,
  output logic                     lane_err_o
);

  localparam int NW      = NUM_PE / 4;
  localparam int WIDX_W  = (NW > 1) ? $clog2(NW) : 1;
  localparam int ENTRY_W = NUM_PE * DATA_W;
  localparam int WORD_W  = 4 * DATA_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [15:0]       PIX_MAX   = 16'(OFM_PIXELS);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(OFM_PIXELS * NW - 1);
  localparam logic [WIDX_W-1:0] WORD_LAST = WIDX_W'(NW - 1);

  logic [1:0]          state_q, state_d;
  logic                cal_q;
  logic [ENTRY_W-1:0]  mem_q [2];
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic [1:0]          count_q, count_d;
  logic [WIDX_W-1:0]   word_q, word_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0]   wr_data_q, wr_data_d;
  logic [15:0]         pixel_cnt_q, pixel_cnt_d;
  logic                overflow_q, overflow_d;
  logic                lane_err_q, lane_err_d;

  logic                cal_rise;
  logic                hs;
  logic                last_word;
  logic                pop;
  logic                slot_free;
  logic                push;
  logic [WIDX_W-1:0]   word_nxt;
  logic [ENTRY_W-1:0]  head_entry;
  logic [ENTRY_W-1:0]  next_entry;
  logic [WORD_W-1:0]   head_words [NW];
  logic [WORD_W-1:0]   next_words [NW];

  assign cal_rise   = cal_start_i & ~cal_q;
  assign hs         = wr_en_q & wr_ready_i;
  assign last_word  = (word_q == WORD_LAST);
  assign pop        = hs & last_word;
  // The head entry stays occupied until its final word handshakes.
  assign slot_free  = (count_q != 2'd2) || pop;
  assign word_nxt   = word_q + WIDX_W'(1);
  assign head_entry = mem_q[rd_ptr_q];
  assign next_entry = mem_q[~rd_ptr_q];

  // Word w carries lanes 4w..4w+3 with the lowest lane in the most significant byte.
  for (genvar gw = 0; gw < NW; gw++) begin : g_word
    assign head_words[gw] = {head_entry[DATA_W*(4*gw)   +: DATA_W],
                             head_entry[DATA_W*(4*gw+1) +: DATA_W],
                             head_entry[DATA_W*(4*gw+2) +: DATA_W],
                             head_entry[DATA_W*(4*gw+3) +: DATA_W]};
    assign next_words[gw] = {next_entry[DATA_W*(4*gw)   +: DATA_W],
                             next_entry[DATA_W*(4*gw+1) +: DATA_W],
                             next_entry[DATA_W*(4*gw+2) +: DATA_W],
                             next_entry[DATA_W*(4*gw+3) +: DATA_W]};
  end

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    word_d      = word_q;
    wr_en_d     = wr_en_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    pixel_cnt_d = pixel_cnt_q;
    overflow_d  = overflow_q;
    lane_err_d  = lane_err_q;
    push        = 1'b0;

    if (cal_rise) begin
      state_d     = ST_ARMED;
      rd_ptr_d    = 1'b0;
      wr_ptr_d    = 1'b0;
      count_d     = 2'd0;
      word_d      = '0;
      wr_en_d     = 1'b0;
      wr_addr_d   = '0;
      pixel_cnt_d = 16'd0;
      overflow_d  = 1'b0;
      lane_err_d  = 1'b0;
    end else begin
      if (hs) begin
        wr_addr_d = (wr_addr_q == ADDR_LAST) ? '0 : wr_addr_q + ADDR_W'(1);
      end

      if (hs && !last_word) begin
        word_d    = word_nxt;
        wr_data_d = head_words[word_nxt];
      end else if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
        word_d   = '0;
        if (count_q == 2'd2) begin
          wr_en_d   = 1'b1;
          wr_data_d = next_words[0];
        end else begin
          wr_en_d = 1'b0;
        end
      end else if (!wr_en_q && (count_q != 2'd0)) begin
        wr_en_d   = 1'b1;
        word_d    = '0;
        wr_data_d = head_words[0];
      end

      if (state_q == ST_ARMED) begin
        if (&valid_i) begin
          if (pixel_cnt_q < PIX_MAX) begin
            if (slot_free) begin
              push        = 1'b1;
              wr_ptr_d    = ~wr_ptr_q;
              pixel_cnt_d = pixel_cnt_q + 16'd1;
            end else begin
              overflow_d = 1'b1;
            end
          end
        end else if (|valid_i) begin
          lane_err_d = 1'b1;
        end
      end

      count_d = count_q + {1'b0, push} - {1'b0, pop};

      if ((state_q == ST_ARMED) && (pixel_cnt_q == PIX_MAX) &&
          (count_q == 2'd0) && !wr_en_q) begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= ST_IDLE;
      cal_q       <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      word_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      pixel_cnt_q <= 16'd0;
      overflow_q  <= 1'b0;
      lane_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cal_q       <= cal_start_i;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      word_q      <= word_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      pixel_cnt_q <= pixel_cnt_d;
      overflow_q  <= overflow_d;
      lane_err_q  <= lane_err_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= ofm_in_i;
    end
  end

  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign pixel_cnt_o = pixel_cnt_q;
  assign done_o      = (state_q == ST_DONE);
  assign overflow_o  = overflow_q;
  assign lane_err_o  = lane_err_q;

endmodule

`default_nettype wire
